// File: rtl/sequenced_decoder_3_8.sv
// sequenced_decoder_3_8: buffers 3-bit indices in a 2-entry FIFO and replays
// each one as a one-hot select line held for HOLD_CYCLES clocks. Each hold is
// followed by GAP_CYCLES all-zero clocks.
module sequenced_decoder_3_8 #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int COUNT_WIDTH = 8
) (
  input  logic       Clock_In,
  input  logic       Reset_In,
  input  logic       Enable_In,
  input  logic [2:0] Encoded_Value_In,
  input  logic       Valid_In,
  output logic       Ready_Out,
  output logic       Data_0_Out,
  output logic       Data_1_Out,
  output logic       Data_2_Out,
  output logic       Data_3_Out,
  output logic       Data_4_Out,
  output logic       Data_5_Out,
  output logic       Data_6_Out,
  output logic       Data_7_Out,
  output logic       Busy_Out,
  output logic       Done_Out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Counter reload values; the counter runs down to zero and never wraps.
  localparam logic [COUNT_WIDTH-1:0] HoldLoad = COUNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [COUNT_WIDTH-1:0] GapLoad  =
    COUNT_WIDTH'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] counter_q, counter_d;
  logic [7:0]             lines_q, lines_d;
  logic [2:0]             fifoMem_q [2];
  logic                   rdPtr_q, wrPtr_q;
  logic [1:0]             count_q, count_d;
  logic                   push, pop;
  logic [2:0]             headIdx;

  // Ready depends only on the registered fill level, so a pop in the same cycle cannot open a slot.
  assign Ready_Out = Enable_In & ~Reset_In & (count_q < 2'd2);
  assign push      = Valid_In & Ready_Out;
  assign headIdx   = fifoMem_q[rdPtr_q];
  assign count_d   = count_q + {1'b0, push} - {1'b0, pop};

  // Next-state logic: a pop from IDLE, from the end of a hold, or from the end of a gap all start a new hold.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    lines_d   = lines_q;
    pop       = 1'b0;
    if (!Enable_In) begin
      state_d   = IDLE;
      counter_d = '0;
      lines_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          lines_d = '0;
          if (count_q != 2'd0) pop = 1'b1;
        end
        DRIVE: begin
          if (counter_q != '0) begin
            counter_d = counter_q - COUNT_WIDTH'(1);
          end else if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            counter_d = GapLoad;
            lines_d   = '0;
          end else if (count_q != 2'd0) begin
            pop = 1'b1;
          end else begin
            state_d   = IDLE;
            counter_d = '0;
            lines_d   = '0;
          end
        end
        GAP: begin
          lines_d = '0;
          if (counter_q != '0) begin
            counter_d = counter_q - COUNT_WIDTH'(1);
          end else if (count_q != 2'd0) begin
            pop = 1'b1;
          end else begin
            state_d   = IDLE;
            counter_d = '0;
          end
        end
        default: begin
          state_d   = IDLE;
          counter_d = '0;
          lines_d   = '0;
        end
      endcase
      if (pop) begin
        state_d   = DRIVE;
        counter_d = HoldLoad;
        lines_d   = 8'b1 << headIdx;
      end
    end
  end

  // State, counter, output lines and FIFO registers; reset flushes everything.
  always_ff @(posedge Clock_In) begin
    if (Reset_In) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      lines_q      <= '0;
      fifoMem_q[0] <= '0;
      fifoMem_q[1] <= '0;
      rdPtr_q      <= 1'b0;
      wrPtr_q      <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      lines_q   <= lines_d;
      count_q   <= count_d;
      if (push) begin
        fifoMem_q[wrPtr_q] <= Encoded_Value_In;
        wrPtr_q            <= ~wrPtr_q;
      end
      if (pop) rdPtr_q <= ~rdPtr_q;
    end
  end

  assign Busy_Out   = (state_q != IDLE) | (count_q != 2'd0);
  assign Done_Out   = (state_q == DRIVE) & (counter_q == '0);
  assign Data_0_Out = lines_q[0];
  assign Data_1_Out = lines_q[1];
  assign Data_2_Out = lines_q[2];
  assign Data_3_Out = lines_q[3];
  assign Data_4_Out = lines_q[4];
  assign Data_5_Out = lines_q[5];
  assign Data_6_Out = lines_q[6];
  assign Data_7_Out = lines_q[7];

endmodule
